// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, operands consumed LSB-first.
// Define SERIAL_SUB_EN to add the sub port (a - b via ~b and carry-in of 1).
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; in_ready only in IDLE, out_valid only in DONE, held until taken.

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [CNT_W-1:0]   r_bitcnt;

    logic               w_accept;
    logic               w_emit;
    logic               w_last;
    logic               w_sum_bit;
    logic               w_carry_next;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_carry_init;

    assign w_accept     = in_valid && (r_state == IDLE);
    assign w_emit       = out_ready && (r_state == DONE);
    assign w_last       = (r_state == RUN) && (r_bitcnt == LAST_CNT);

    assign w_sum_bit    = r_op_a[0] ^ r_op_b[0] ^ r_carry;
    assign w_carry_next = (r_op_a[0] & r_op_b[0]) | (r_op_a[0] & r_carry) |
                          (r_op_b[0] & r_carry);

`ifdef SERIAL_SUB_EN
    // Two's-complement subtract: invert B and inject the +1 as the initial carry.
    assign w_b_load     = sub ? ~b : b;
    assign w_carry_init = sub;
`else
    assign w_b_load     = b;
    assign w_carry_init = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (w_emit) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_bitcnt <= '0;
        end else if (w_accept) begin
            r_op_a   <= a;
            r_op_b   <= w_b_load;
            r_sum    <= '0;
            r_carry  <= w_carry_init;
            r_bitcnt <= '0;
        end else if (r_state == RUN) begin
            r_op_a   <= {1'b0, r_op_a[WIDTH-1:1]};
            r_op_b   <= {1'b0, r_op_b[WIDTH-1:1]};
            r_sum    <= {w_sum_bit, r_sum[WIDTH-1:1]};
            r_carry  <= w_carry_next;
            r_bitcnt <= r_bitcnt + CNT_W'(1);
            if (w_last) begin
                r_cout <= w_carry_next;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == RUN) || (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign dbg_state = r_state;

endmodule
